// File: rtl/dsp48a1_mac_sequencer.sv
// rtl/dsp48a1_mac_sequencer.sv - sequences one DSP48A1 slice as a dot-product MAC engine
module dsp48a1_mac_sequencer #(
    parameter int LEN_W   = 8,
    parameter int DSP_LAT = 3,
    parameter int OPM_DLY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             bias_en,
    input  logic [47:0]      bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [17:0]      a_in,
    input  logic [17:0]      b_in,
    output logic [17:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [47:0]      dsp_c,
    output logic [7:0]       dsp_opmode,
    output logic             dsp_ce,
    input  logic [47:0]      dsp_p,
    output logic             busy,
    output logic             done,
    output logic [47:0]      result
);

    localparam int CW = $clog2(DSP_LAT + 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DSP_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_rem;
    logic             r_first;
    logic             r_bias_en;
    logic [CW-1:0]    r_drain_cnt;
    logic [47:0]      r_result;
    logic [7:0]       r_opm [OPM_DLY];
    logic             w_beat;
    logic             w_last_beat;
    logic             w_capture;
    logic [7:0]       w_opm_gen;

    assign w_beat      = in_valid && (r_state == S_RUN);
    assign w_last_beat = w_beat && (r_rem == LEN_W'(1));
    assign w_capture   = (r_state == S_DRAIN) && (r_drain_cnt == DRAIN_LAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (w_last_beat) w_next = S_DRAIN;
            S_DRAIN: if (w_capture) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Until the first beat lands, P is (re)loaded with 0 or C so stale P never leaks in
    always_comb begin
        w_opm_gen = 8'h00;
        if (r_state == S_RUN) begin
            if (w_beat)
                w_opm_gen = r_first ? (r_bias_en ? 8'h0D : 8'h01) : 8'h09;
            else
                w_opm_gen = r_first ? (r_bias_en ? 8'h0C : 8'h00) : 8'h08;
        end else if (r_state == S_DRAIN) begin
            w_opm_gen = 8'h08;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rem       <= '0;
            r_first     <= 1'b0;
            r_bias_en   <= 1'b0;
            r_drain_cnt <= '0;
            r_result    <= '0;
            for (int i = 0; i < OPM_DLY; i++) r_opm[i] <= 8'h00;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && start) begin
                r_rem     <= len;
                r_first   <= 1'b1;
                r_bias_en <= bias_en;
                if (len == '0) r_result <= bias_en ? bias : 48'd0;
            end
            if (w_beat) begin
                r_rem   <= r_rem - 1'b1;
                r_first <= 1'b0;
            end
            if (w_last_beat) r_drain_cnt <= '0;
            else if (r_state == S_DRAIN) r_drain_cnt <= r_drain_cnt + 1'b1;
            if (w_capture) r_result <= dsp_p;
            r_opm[0] <= w_opm_gen;
            for (int i = 1; i < OPM_DLY; i++) r_opm[i] <= r_opm[i-1];
        end
    end

    assign in_ready   = (r_state == S_RUN);
    assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign dsp_ce     = busy;
    assign done       = (r_state == S_DONE);
    assign result     = r_result;
    assign dsp_a      = w_beat ? a_in : 18'd0;
    assign dsp_b      = w_beat ? b_in : 18'd0;
    assign dsp_c      = bias;
    assign dsp_opmode = r_opm[OPM_DLY-1];

endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// tb/tb_dsp48a1_mac_sequencer.sv - randomized model-checked bench with a DSP48A1 slice model
module tb_dsp48a1_mac_sequencer;

    localparam int DSP_LAT = 3;

    logic        clk = 1'b0;
    logic        rst, start, bias_en, in_valid;
    logic [7:0]  len;
    logic [47:0] bias;
    logic [17:0] a_in, b_in;
    logic        in_ready, dsp_ce, busy, done;
    logic [17:0] dsp_a, dsp_b;
    logic [47:0] dsp_c, dsp_p, result;
    logic [7:0]  dsp_opmode;

    dsp48a1_mac_sequencer #(.LEN_W(8), .DSP_LAT(DSP_LAT), .OPM_DLY(1)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .bias_en(bias_en), .bias(bias),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_opmode(dsp_opmode),
        .dsp_ce(dsp_ce), .dsp_p(dsp_p), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Slice: A1/B1 -> M -> P, OPMODE registered, C combinational
    logic [17:0] s_a1, s_b1;
    logic [35:0] s_m;
    logic [7:0]  s_opm;
    logic [47:0] s_p, s_x, s_z;
    always_comb begin
        s_x = (s_opm[1:0] == 2'b01) ? {12'd0, s_m} : 48'd0;
        case (s_opm[3:2])
            2'b10:   s_z = s_p;
            2'b11:   s_z = dsp_c;
            default: s_z = 48'd0;
        endcase
    end
    always @(posedge clk) begin
        if (rst) begin
            s_a1 <= '0; s_b1 <= '0; s_m <= '0; s_opm <= '0; s_p <= '0;
        end else if (dsp_ce) begin
            s_a1  <= dsp_a;
            s_b1  <= dsp_b;
            s_m   <= s_a1 * s_b1;
            s_opm <= dsp_opmode;
            s_p   <= s_z + s_x;
        end
    end
    assign dsp_p = s_p;

    int total = 0;
    int bad   = 0;
    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: a job is a count of pairs and a running wrapped sum; timing follows from beat cycles
    bit          chk_en = 0;
    bit          m_active = 0;
    bit          m_done_known = 0;
    int          m_len = 0, m_beats = 0;
    longint      m_start = 0, m_done = 0;
    logic [47:0] m_sum = '0, m_result = '0;

    always @(negedge clk) begin
        bit e_rdy, e_busy, e_done, beat, was_active;
        if (chk_en) begin
            e_rdy  = m_active && m_len != 0 && cyc > m_start && m_beats < m_len;
            e_busy = m_active && m_len != 0 && cyc > m_start && (m_beats < m_len || cyc < m_done);
            e_done = m_active && m_done_known && cyc == m_done;
            beat   = e_rdy && in_valid;
            if (e_done) m_result = m_sum;
            check("in_ready", in_ready, e_rdy);
            check("busy", busy, e_busy);
            check("dsp_ce", dsp_ce, e_busy);
            check("done", done, e_done);
            check("result", result, m_result);
            check("dsp_a", dsp_a, beat ? a_in : 18'd0);
            check("dsp_b", dsp_b, beat ? b_in : 18'd0);
            check("dsp_c", dsp_c, bias);
            check("opmode_hi", dsp_opmode[7:4], 4'h0);
            was_active = m_active;
            if (beat) begin
                m_beats++;
                m_sum = m_sum + 48'(a_in) * 48'(b_in);
                if (m_beats == m_len) begin
                    m_done = cyc + DSP_LAT + 1;
                    m_done_known = 1;
                end
            end
            if (e_done) m_active = 0;
            if (start && !was_active) begin
                m_active = 1;
                m_len = int'(len);
                m_beats = 0;
                m_start = cyc;
                m_sum = bias_en ? bias : 48'd0;
                m_done_known = (len == 8'd0);
                m_done = cyc + 1;
            end
        end
        if (rst) begin
            chk_en = 1;
            m_active = 0;
            m_done_known = 0;
            m_result = '0;
        end
    end

    logic [17:0] qa[$], qb[$];

    task automatic run_job(input int n, input bit be, input logic [47:0] bv, input int vpct,
                           input bit use_q, input bit pulse, input bit gap,
                           output logic [47:0] res, output longint dlat);
        int idx = 0, cnt = 0, gapcnt = 0;
        bit got = 0;
        longint st;
        res = '0;
        dlat = 0;
        @(posedge clk); #1;
        start = 1; len = n[7:0]; bias_en = be; bias = bv; in_valid = 0;
        st = cyc;
        @(posedge clk); #1;
        start = 0;
        forever begin
            in_valid = ($urandom_range(99) < vpct);
            if (gap && idx == 1 && gapcnt < 2) begin
                in_valid = 0;
                gapcnt++;
            end
            a_in = use_q ? (idx < qa.size() ? qa[idx] : 18'd0) : 18'($urandom);
            b_in = use_q ? (idx < qb.size() ? qb[idx] : 18'd0) : 18'($urandom);
            start = pulse && cnt == 1;
            if (start) len = 8'd9;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            if (done) begin
                got = 1;
                res = result;
                dlat = cyc - st;
                break;
            end
            cnt++;
            if (cnt > 3000) break;
            @(posedge clk); #1;
        end
        check("job_completes", got, 1'b1);
        @(posedge clk); #1;
        start = 0; in_valid = 0;
    endtask

    task automatic load_q(input int n, input logic [17:0] av, input logic [17:0] bv);
        qa.delete(); qb.delete();
        for (int i = 0; i < n; i++) begin qa.push_back(av); qb.push_back(bv); end
    endtask

    initial begin
        logic [47:0] r;
        longint      dl;
        rst = 1; start = 0; len = 0; bias_en = 0; bias = 0; in_valid = 0; a_in = 0; b_in = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_result", result, 48'd0);
        check("rst_opmode", dsp_opmode, 8'h00);
        check("rst_ce", dsp_ce, 1'b0);

        qa = '{18'd1, 18'd2, 18'd3}; qb = '{18'd4, 18'd5, 18'd6};
        run_job(3, 0, 48'd0, 100, 1, 0, 0, r, dl);
        check("dot3_result", r, 48'd32);
        check("dot3_latency", dl, 64'd7);
        run_job(3, 1, 48'd100, 100, 1, 0, 0, r, dl);
        check("dot3_bias_result", r, 48'd132);
        run_job(3, 0, 48'd0, 100, 1, 0, 1, r, dl);
        check("dot3_gap_result", r, 48'd32);
        run_job(0, 0, 48'd0, 100, 1, 0, 0, r, dl);
        check("len0_result", r, 48'd0);
        run_job(0, 1, 48'd77, 100, 1, 0, 0, r, dl);
        check("len0_bias_result", r, 48'd77);
        load_q(255, 18'h3FFFF, 18'h3FFFF);
        run_job(255, 0, 48'd0, 100, 1, 0, 0, r, dl);
        check("max_result", r, 48'd17523332874495);
        load_q(1, 18'd5, 18'd5);
        run_job(1, 1, 48'hFFFF_FFFF_FFF0, 100, 1, 0, 0, r, dl);
        check("wrap_result", r, 48'd9);
        qa = '{18'd1, 18'd2, 18'd3}; qb = '{18'd4, 18'd5, 18'd6};
        run_job(3, 0, 48'd0, 60, 1, 1, 0, r, dl);
        check("start_in_run_result", r, 48'd32);

        @(posedge clk); #1;
        start = 1; len = 8'd5; bias_en = 0;
        @(posedge clk); #1;
        start = 0; in_valid = 1; a_in = 18'd3; b_in = 18'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; in_valid = 0;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", in_ready, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_result", result, 48'd0);
        check("midrst_opmode", dsp_opmode, 8'h00);
        load_q(1, 18'd7, 18'd9);
        run_job(1, 0, 48'd0, 100, 1, 0, 0, r, dl);
        check("after_rst_result", r, 48'd63);

        for (int j = 0; j < 40; j++) begin
            int n;
            n = $urandom_range(12);
            run_job(n, 1'($urandom), {16'($urandom), 32'($urandom)}, $urandom_range(100, 40),
                    0, (n >= 4) && ($urandom_range(1) == 1), 0, r, dl);
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
